axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI-subset responder (slave) that terminates single-beat read and write transactions from an AXI initiator (CPU side) and drives a synchronous single-port SRAM.
- Sits between the CPU's AXI master port and the on-chip SRAM macro.
- Strictly one transaction outstanding. Writes win over reads when both are pending in IDLE, which guarantees read-after-write ordering to the same address.

Parameters:
- ADDR_W, 32, AXI byte-address width.
- DATA_W, 64, data width (fixed 64; 8 byte lanes).
- ID_W, 4, AXI ID width.
- SRAM_AW, 10, SRAM word-address width (1024 x 64-bit words).

Ports:
- clk  in  1  clock; all logic on posedge.
- resetn  in  1  synchronous reset, active-low.
- awid  in  ID_W  write ID.
- awaddr  in  ADDR_W  write byte address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_W  write data.
- wstrb  in  8  byte strobes.
- wlast  in  1  last beat; always 1 from a compliant initiator; ignored.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bid  out  ID_W  response ID (registered awid).
- bresp  out  2  00 OKAY, 10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- arid  in  ID_W  read ID.
- araddr  in  ADDR_W  read byte address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rid  out  ID_W  read ID (registered arid).
- rdata  out  DATA_W  read data.
- rresp  out  2  00 OKAY, 10 SLVERR.
- rlast  out  1  equal to rvalid (single beat).
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- sram_en  out  1  SRAM access enable.
- sram_we  out  8  per-byte write enable; 0 for reads.
- sram_addr  out  SRAM_AW  word address = addr[SRAM_AW+2:3].
- sram_wdata  out  DATA_W  write data.
- sram_rdata  in  DATA_W  read data, valid exactly one cycle after a sram_en read cycle.

Behaviour:
- Reset: clk and resetn, synchronous active-low. While resetn=0 at a posedge:
  - state <= IDLE.
  - awready, wready, arready, bvalid, rvalid, rlast, sram_en = 0; sram_we = 0.
  - bresp, rresp, bid, rid, rdata = 0.
  - Internal captured-AW and captured-W flags cleared.
  - Reset mid-transaction abandons it; no response is issued.
- Address legality: illegal if addr[ADDR_W-1:SRAM_AW+3] != 0. An illegal transaction gets no SRAM access and a SLVERR response. Low address bits [2:0] are ignored.
- States: IDLE, W_COLLECT, W_EXEC, W_RESP, R_ISSUE, R_CAPT, R_RESP.
- IDLE:
  - awready=1, wready=1, arready = !awvalid && !wvalid (write priority).
  - AW and W handshakes in the same cycle -> W_EXEC.
  - Only one of them -> W_COLLECT, with that channel captured.
  - AR handshake -> R_ISSUE.
- W_COLLECT:
  - Only the missing channel's ready=1; arready=0.
  - On its handshake -> W_EXEC.
- W_EXEC (1 cycle):
  - If legal: sram_en=1, sram_we=wstrb, sram_addr and sram_wdata from captured values.
  - If illegal: sram_en=0.
  - Next state W_RESP.
- W_RESP:
  - bvalid=1, bid=captured awid, bresp per legality.
  - Held stable until bready=1; the handshake cycle -> IDLE.
  - bvalid is deasserted in IDLE; the earliest next AW/W acceptance is the cycle after the B handshake.
- R_ISSUE (1 cycle): sram_en=1, sram_we=0 if legal; otherwise no access. Next state R_CAPT.
- R_CAPT (1 cycle):
  - rdata <= sram_rdata if legal, else 0.
  - Next state R_RESP.
- R_RESP:
  - rvalid=rlast=1, rid=captured arid, rresp per legality.
  - rdata, rid, rresp held stable until rready=1.
  - Handshake -> IDLE.
- Latency:
  - AW+W handshake at edge N: SRAM write in cycle N..N+1, bvalid high from edge N+2.
  - AR handshake at edge N: rvalid high from edge N+3.
- Output timing: readies, valids, and SRAM controls are decoded from registered state only; no combinational path from valid inputs to ready outputs other than the IDLE arready term.
- Deadlock-free: rready or bready tied high completes each transaction in minimum time. Valids already asserted out of reset are accepted on the first IDLE cycle after reset.

Test Plan:
- Write then read: AW(addr 0x4, id 1) and W(0x12345678, wstrb 0xFF) in the same cycle, bready=1 -> SRAM word 0 written, bvalid with bid=1, bresp=00. Then AR 0x4 -> rvalid 3 edges after handshake, rdata=0x12345678, rresp=00, rlast=1.
- Split write: W presented 3 cycles before AW(0x10).
  - Before AW: wready drops after the W handshake, arready=0 throughout.
  - After AW: the write lands in word 2.
- Byte strobes: word 5 prefilled with 0xFFFF..FF; write 0 with wstrb 0x0F -> read back 0xFFFFFFFF00000000.
- Simultaneous arvalid, awvalid, wvalid in IDLE -> write accepted first (arready=0). The read is accepted the cycle after the B handshake and returns the new data.
- Backpressure and error:
  - Hold rready=0 for 5 cycles -> rvalid, rdata, rid stable throughout.
  - Write to 0x10000 (out of range) -> sram_en never asserted, bresp=10.
- Reset mid-read: drive resetn=0 during R_CAPT -> next edge rvalid=0 and state IDLE; after release, a new read completes normally.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-beat AXI-subset responder that drives a synchronous
// single-port SRAM. Only one transaction is in flight at a time. Writes take
// priority over reads in IDLE, so a read issued after a write to the same
// address always observes the written data.
module axi_sram_slave #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4,
  parameter int SRAM_AW = 10
) (
  input  logic              clk,
  input  logic              resetn,
  // write address channel
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  // write data channel
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // write response channel
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // read address channel
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  // read data channel
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // SRAM port
  output logic              sram_en,
  output logic [7:0]        sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_COLLECT = 3'd1,
    W_EXEC    = 3'd2,
    W_RESP    = 3'd3,
    R_ISSUE   = 3'd4,
    R_CAPT    = 3'd5,
    R_RESP    = 3'd6
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // An address is legal only if every bit above the SRAM word range is zero.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return (a[ADDR_W-1:SRAM_AW+3] == {(ADDR_W-SRAM_AW-3){1'b0}});
  endfunction

  state_t              state_r, state_n;
  logic                aw_got_r, aw_got_n;
  logic                w_got_r, w_got_n;
  logic [ID_W-1:0]     awid_r, awid_n;
  logic [ADDR_W-1:0]   awaddr_r, awaddr_n;
  logic [DATA_W-1:0]   wdata_r, wdata_n;
  logic [7:0]          wstrb_r, wstrb_n;
  logic [ID_W-1:0]     arid_r, arid_n;
  logic [ADDR_W-1:0]   araddr_r, araddr_n;
  logic                arready_base_r;
  logic                aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                wr_legal_n, rd_legal_n;
  logic                unused_wlast;

  // wlast is always 1 for single-beat bursts and carries no information.
  assign unused_wlast = wlast;

  // arready is the one output with a direct path from inputs: a pending write
  // in IDLE blocks the read so the write is served first.
  assign arready = arready_base_r & ~awvalid & ~wvalid;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;
  assign b_hs  = bvalid & bready;
  assign r_hs  = rvalid & rready;

  assign awid_n   = aw_hs ? awid   : awid_r;
  assign awaddr_n = aw_hs ? awaddr : awaddr_r;
  assign wdata_n  = w_hs  ? wdata  : wdata_r;
  assign wstrb_n  = w_hs  ? wstrb  : wstrb_r;
  assign arid_n   = ar_hs ? arid   : arid_r;
  assign araddr_n = ar_hs ? araddr : araddr_r;

  assign wr_legal_n = addr_legal(awaddr_n);
  assign rd_legal_n = addr_legal(araddr_n);

  // Next-state and channel-capture flag logic.
  always_comb begin
    state_n  = state_r;
    aw_got_n = aw_got_r;
    w_got_n  = w_got_r;
    case (state_r)
      IDLE: begin
        aw_got_n = aw_hs;
        w_got_n  = w_hs;
        if (aw_hs && w_hs) begin
          state_n = W_EXEC;
        end else if (aw_hs || w_hs) begin
          state_n = W_COLLECT;
        end else if (ar_hs) begin
          state_n = R_ISSUE;
        end else begin
          state_n = IDLE;
        end
      end
      W_COLLECT: begin
        aw_got_n = aw_got_r | aw_hs;
        w_got_n  = w_got_r | w_hs;
        if (aw_got_n && w_got_n) begin
          state_n = W_EXEC;
        end else begin
          state_n = W_COLLECT;
        end
      end
      W_EXEC:  state_n = W_RESP;
      W_RESP: begin
        if (b_hs) begin
          state_n = IDLE;
        end else begin
          state_n = W_RESP;
        end
      end
      R_ISSUE: state_n = R_CAPT;
      R_CAPT:  state_n = R_RESP;
      R_RESP: begin
        if (r_hs) begin
          state_n = IDLE;
        end else begin
          state_n = R_RESP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, captured request fields and all registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r        <= IDLE;
      aw_got_r       <= 1'b0;
      w_got_r        <= 1'b0;
      awid_r         <= '0;
      awaddr_r       <= '0;
      wdata_r        <= '0;
      wstrb_r        <= 8'h00;
      arid_r         <= '0;
      araddr_r       <= '0;
      arready_base_r <= 1'b0;
      awready        <= 1'b0;
      wready         <= 1'b0;
      bvalid         <= 1'b0;
      bid            <= '0;
      bresp          <= 2'b00;
      rvalid         <= 1'b0;
      rlast          <= 1'b0;
      rid            <= '0;
      rdata          <= '0;
      rresp          <= 2'b00;
      sram_en        <= 1'b0;
      sram_we        <= 8'h00;
      sram_addr      <= '0;
      sram_wdata     <= '0;
    end else begin
      state_r  <= state_n;
      aw_got_r <= aw_got_n;
      w_got_r  <= w_got_n;
      awid_r   <= awid_n;
      awaddr_r <= awaddr_n;
      wdata_r  <= wdata_n;
      wstrb_r  <= wstrb_n;
      arid_r   <= arid_n;
      araddr_r <= araddr_n;

      // Readies are decoded from the state being entered, so acceptance
      // resumes the cycle right after a response handshake.
      awready        <= (state_n == IDLE) || ((state_n == W_COLLECT) && !aw_got_n);
      wready         <= (state_n == IDLE) || ((state_n == W_COLLECT) && !w_got_n);
      arready_base_r <= (state_n == IDLE);

      // SRAM controls are valid during the W_EXEC / R_ISSUE cycle itself.
      sram_en <= ((state_n == W_EXEC) && wr_legal_n) || ((state_n == R_ISSUE) && rd_legal_n);
      sram_we <= ((state_n == W_EXEC) && wr_legal_n) ? wstrb_n : 8'h00;
      if (state_n == W_EXEC) begin
        sram_addr  <= awaddr_n[SRAM_AW+2:3];
        sram_wdata <= wdata_n;
      end else if (state_n == R_ISSUE) begin
        sram_addr  <= araddr_n[SRAM_AW+2:3];
      end

      // Write response: fields latched while executing, valid one cycle into
      // W_RESP and held until accepted.
      if (state_r == W_EXEC) begin
        bid   <= awid_r;
        bresp <= addr_legal(awaddr_r) ? RESP_OKAY : RESP_SLVERR;
      end
      bvalid <= (state_r == W_RESP) && !b_hs;

      // Read response: SRAM data arrives during R_CAPT; illegal reads return 0.
      if (state_r == R_CAPT) begin
        rdata <= addr_legal(araddr_r) ? sram_rdata : '0;
        rid   <= arid_r;
        rresp <= addr_legal(araddr_r) ? RESP_OKAY : RESP_SLVERR;
      end
      rvalid <= (state_r == R_RESP) && !r_hs;
      rlast  <= (state_r == R_RESP) && !r_hs;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave. A behavioural SRAM sits on the memory
// port; a transaction-level model (reference memory + expected-response
// queues) predicts every B and R beat, and a single compare process checks
// the DUT on every negative clock edge.
module tb_axi_sram_slave;

  logic        clk;
  logic        resetn;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        sram_en;
  logic [7:0]  sram_we;
  logic [9:0]  sram_addr;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata;

  axi_sram_slave dut (
    .clk(clk), .resetn(resetn),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_hs   = 0;
  int ar_hs   = 0;
  int b_hs    = 0;
  int sram_en_cnt = 0;
  logic prev_b = 1'b0;
  logic prev_r = 1'b0;
  logic [63:0] last_rdata = 64'd0;

  // Posedge counter used to time handshakes and response latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous SRAM: byte-masked writes, 1-cycle read latency.
  logic [63:0] sram_mem [0:1023];
  always @(posedge clk) begin
    if (sram_en) begin
      for (int b = 0; b < 8; b++)
        if (sram_we[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      if (sram_we == 8'h00) sram_rdata <= sram_mem[sram_addr];
    end
  end

  // Transaction-level reference model.
  logic [63:0] ref_mem [0:1023];
  logic [5:0]  exp_b [$];
  logic [69:0] exp_r [$];

  function automatic logic legal(input logic [31:0] a);
    return a[31:13] == 19'd0;
  endfunction

  task automatic check(input string nm, input logic [69:0] act, input logic [69:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_write(input logic [3:0] id, input logic [31:0] a,
                             input logic [63:0] d, input logic [7:0] s);
    logic [63:0] w;
    if (legal(a)) begin
      w = ref_mem[a[12:3]];
      for (int b = 0; b < 8; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
      ref_mem[a[12:3]] = w;
    end
    exp_b.push_back({id, legal(a) ? 2'b00 : 2'b10});
  endtask

  task automatic model_read(input logic [3:0] id, input logic [31:0] a);
    exp_r.push_back({id, legal(a) ? ref_mem[a[12:3]] : 64'd0, legal(a) ? 2'b00 : 2'b10});
  endtask

  // Compare process: checks every response beat against the model and the
  // cycle-level rules (latency, write priority, rlast), once per cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_b.delete();
      exp_r.delete();
      prev_b <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      if ((awvalid && awready) || (wvalid && wready)) wr_hs = cyc + 1;
      if (arvalid && arready) ar_hs = cyc + 1;
      if (awvalid || wvalid) check("arready_blocked", 70'(arready), 70'd0);
      if (sram_en) sram_en_cnt++;
      if (bvalid) begin
        if (!prev_b) check("b_latency", 70'(cyc - wr_hs), 70'd2);
        if (exp_b.size() == 0) check("b_unexpected", 70'd1, 70'd0);
        else check("b_id_resp", 70'({bid, bresp}), 70'(exp_b[0]));
        if (bready && exp_b.size() != 0) begin
          b_hs = cyc + 1;
          void'(exp_b.pop_front());
        end
      end
      if (rvalid) begin
        if (!prev_r) check("r_latency", 70'(cyc - ar_hs), 70'd3);
        check("rlast", 70'(rlast), 70'd1);
        if (exp_r.size() == 0) check("r_unexpected", 70'd1, 70'd0);
        else check("r_id_data_resp", {rid, rdata, rresp}, exp_r[0]);
        if (rready && exp_r.size() != 0) begin
          last_rdata = rdata;
          void'(exp_r.pop_front());
        end
      end
      prev_b <= bvalid;
      prev_r <= rvalid;
    end
  end

  // Present the requested valids, drop each after its handshake. With
  // aw_dly > 0, AW appears that many cycles after W.
  task automatic drive(input bit do_aw, input bit do_w, input bit do_ar,
                       input int aw_dly, input bit chk_gap);
    bit pend_aw, aw_f, w_f, ar_f, done;
    int dly;
    pend_aw = do_aw;
    dly     = aw_dly;
    wvalid  = do_w;
    arvalid = do_ar;
    awvalid = do_aw && (aw_dly == 0);
    done    = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      ar_f = arvalid && arready;
      if (chk_gap && !wvalid && !awvalid && pend_aw) begin
        check("gap_wready", 70'(wready), 70'd0);
        check("gap_arready", 70'(arready), 70'd0);
      end
      @(posedge clk); #1;
      if (aw_f) begin awvalid = 1'b0; pend_aw = 1'b0; end
      if (w_f) wvalid = 1'b0;
      if (ar_f) arvalid = 1'b0;
      if (pend_aw && !awvalid) begin
        dly--;
        if (dly <= 0) awvalid = 1'b1;
      end
      done = !pend_aw && !wvalid && !arvalid;
    end
    if (!done) begin
      check("hs_timeout", 70'd1, 70'd0);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    end
  endtask

  // Wait until every expected response has been seen, bounded.
  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (exp_b.size() == 0 && exp_r.size() == 0) ok = 1'b1;
    end
    if (!ok) check("resp_timeout", 70'd1, 70'd0);
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] a,
                    input logic [63:0] d, input logic [7:0] s, input int dly);
    awid = id; awaddr = a; wdata = d; wstrb = s;
    model_write(id, a, d, s);
    drive(1'b1, 1'b1, 1'b0, dly, dly > 0);
    wait_done();
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] a);
    arid = id; araddr = a;
    model_read(id, a);
    drive(1'b0, 1'b0, 1'b1, 0, 1'b0);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: no finish after 200000 time units");
    $fatal(1);
  end

  initial begin
    logic [63:0] held_data;
    logic [3:0]  held_id;
    int          en_before;
    bit          seen;
    resetn = 1'b0; bready = 1'b1; rready = 1'b1; wlast = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    awid = 4'd0; awaddr = 32'd0; wdata = 64'd0; wstrb = 8'h00;
    arid = 4'd0; araddr = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 70'({awready, wready, arready, bvalid, rvalid, rlast, sram_en}), 70'd0);
    check("reset_we", 70'(sram_we), 70'd0);
    check("reset_fields", 70'({bid, rid, bresp, rresp}), 70'd0);
    check("reset_rdata", 70'(rdata), 70'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Write then read, AW and W together
    wr(4'd1, 32'h4, 64'h12345678, 8'hFF, 0);
    check("t1_sram_word0", 70'(sram_mem[0]), 70'h12345678);
    rd(4'd2, 32'h4);
    check("t1_rdata", 70'(last_rdata), 70'h12345678);

    // Split write: W leads AW by 3 cycles
    wr(4'd3, 32'h10, 64'hA5A5_0000_1111_2222, 8'hFF, 3);
    check("t2_sram_word2", 70'(sram_mem[2]), 70'hA5A5_0000_1111_2222);
    rd(4'd4, 32'h10);

    // Byte strobes on word 5
    wr(4'd5, 32'h28, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    wr(4'd5, 32'h28, 64'h0, 8'h0F, 0);
    rd(4'd6, 32'h28);
    check("t3_strobe_rdata", 70'(last_rdata), 70'hFFFF_FFFF_0000_0000);

    // Simultaneous AR/AW/W: write first, read right after B handshake
    awid = 4'd7; awaddr = 32'h30; wdata = 64'hDEAD_BEEF_CAFE_F00D; wstrb = 8'hFF;
    arid = 4'd8; araddr = 32'h30;
    model_write(4'd7, 32'h30, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    model_read(4'd8, 32'h30);
    drive(1'b1, 1'b1, 1'b1, 0, 1'b0);
    wait_done();
    check("t4_ar_after_b", 70'(ar_hs - b_hs), 70'd1);
    check("t4_raw_rdata", 70'(last_rdata), 70'hDEAD_BEEF_CAFE_F00D);

    // Read backpressure: rready low for 5 cycles
    rready = 1'b0;
    arid = 4'd9; araddr = 32'h10;
    model_read(4'd9, 32'h10);
    drive(1'b0, 1'b0, 1'b1, 0, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (rvalid) seen = 1'b1;
    end
    check("t5_rvalid_seen", 70'(seen), 70'd1);
    held_data = rdata;
    held_id   = rid;
    check("t5_held_data", 70'(held_data), 70'hA5A5_0000_1111_2222);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("t5_rvalid_stable", 70'(rvalid), 70'd1);
      check("t5_rdata_stable", 70'(rdata), 70'(held_data));
      check("t5_rid_stable", 70'(rid), 70'(held_id));
    end
    @(posedge clk); #1;
    rready = 1'b1;
    wait_done();

    // Out-of-range write and read: no SRAM access, SLVERR
    en_before = sram_en_cnt;
    wr(4'd10, 32'h10000, 64'h55, 8'hFF, 0);
    rd(4'd11, 32'h10000);
    check("t6_no_sram_access", 70'(sram_en_cnt - en_before), 70'd0);

    // Reset during R_CAPT abandons the read
    arid = 4'd12; araddr = 32'h28;
    model_read(4'd12, 32'h28);
    drive(1'b0, 1'b0, 1'b1, 0, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t7_rvalid_after_reset", 70'(rvalid), 70'd0);
    check("t7_awready_in_reset", 70'(awready), 70'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t7_idle_after_reset", 70'({awready, wready, arready}), 70'b111);
    @(posedge clk); #1;
    rd(4'd13, 32'h28);
    check("t7_read_after_reset", 70'(last_rdata), 70'hFFFF_FFFF_0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
